// File: rtl/cpu_path_receiver.sv
// Snoops CPU data-bus stores into a reserved window, latches the Dijkstra path on CPU_stop and
// serves it node by node. Define PATH_REVERSE_EN to serve the buffer end-first.
module cpu_path_receiver #(
  parameter logic [31:0] PATH_BASE_ADDR = 32'h0000_0100,
  parameter logic [31:0] LEN_ADDR       = 32'h0000_00FC,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned NODE_W         = 5
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              CPU_MemWrite,
  input  logic [31:0]       CPU_DataAdr,
  input  logic [31:0]       CPU_WriteData,
  input  logic              CPU_stop,
  input  logic              path_clear,
  input  logic              node_changed,
  output logic [NODE_W-1:0] next_node,
  output logic              path_valid,
  output logic [5:0]        path_len,
  output logic [4:0]        path_index,
  output logic              path_done,
  output logic              addr_err
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DepthW   = 32'(DEPTH);
  localparam logic [29:0] BaseWord = PATH_BASE_ADDR[31:2];
  localparam logic [29:0] LenWord  = LEN_ADDR[31:2];

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SERVE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              stop_q;
  logic [5:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;
  logic [NODE_W-1:0] node_q, node_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [NODE_W-1:0] node_mem [DEPTH];

  logic [29:0]     word, off;
  logic            capture_en, hit_len, hit_buf, hit_err, stop_edge;
  logic [IdxW-1:0] wr_slot, rd_slot;
  logic            unused_addr_lsbs;

  // Byte offsets select the same word.
  assign unused_addr_lsbs = ^CPU_DataAdr[1:0];
  assign word       = CPU_DataAdr[31:2];
  assign off        = word - BaseWord;
  assign capture_en = CPU_MemWrite && (state_q == CAPTURE) && !path_clear;
  assign hit_len    = capture_en && (word == LenWord);
  assign hit_buf    = capture_en && (word >= BaseWord) && ({2'b00, off} < DepthW);
  assign hit_err    = capture_en && (word >= BaseWord) && ({2'b00, off} >= DepthW) &&
                      ({2'b00, off} < 32'd32);
  assign wr_slot    = off[IdxW-1:0];
  assign stop_edge  = CPU_stop & ~stop_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    node_d  = node_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    rd_slot = '0;
    if (path_clear) begin
      state_d = CAPTURE;
      len_d   = 6'd0;
      idx_d   = 5'd0;
      node_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (hit_len) begin
            if (CPU_WriteData > DepthW) begin
              len_d = DepthW[5:0];
              err_d = 1'b1;
            end else begin
              len_d = CPU_WriteData[5:0];
            end
          end
          if (hit_err) err_d = 1'b1;
          if (stop_edge) begin
            if (len_d == 6'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = SERVE;
              valid_d = 1'b1;
`ifdef PATH_REVERSE_EN
              idx_d = 5'(len_d - 6'd1);
`else
              idx_d = 5'd0;
`endif
              rd_slot = idx_d[IdxW-1:0];
              // Forward a store landing in the first-served slot on the stop edge itself.
              node_d  = (hit_buf && (wr_slot == rd_slot)) ? CPU_WriteData[NODE_W-1:0]
                                                          : node_mem[rd_slot];
            end
          end
        end
        SERVE: begin
          if (node_changed) begin
`ifdef PATH_REVERSE_EN
            if (idx_q == 5'd0) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q - 5'd1;
              rd_slot = idx_d[IdxW-1:0];
              node_d  = node_mem[rd_slot];
            end
`else
            if ({1'b0, idx_q} == len_q - 6'd1) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 5'd1;
              rd_slot = idx_d[IdxW-1:0];
              node_d  = node_mem[rd_slot];
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stop_q  <= 1'b0;
      len_q   <= 6'd0;
      idx_q   <= 5'd0;
      node_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= CPU_stop;
      len_q   <= len_d;
      idx_q   <= idx_d;
      node_q  <= node_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (hit_buf) node_mem[wr_slot] <= CPU_WriteData[NODE_W-1:0];
  end

  assign next_node  = node_q;
  assign path_valid = valid_q;
  assign path_len   = len_q;
  assign path_index = idx_q;
  assign path_done  = done_q;
  assign addr_err   = err_q;

endmodule

// File: doc/cpu_path_receiver.md
Name: cpu_path_receiver

Overview:
- Receiving end of the CPU path-output interface; the CPU driver is the sending end of the same interface.
- Snoops the RISC-V CPU data-bus stores: CPU_MemWrite, CPU_DataAdr, CPU_WriteData.
- Captures the node list that the Dijkstra program writes to a reserved memory window, then latches it when CPU_stop rises.
- Serves the nodes one at a time to the path-mapping/line-follower logic, advancing on each node_changed pulse.

Parameters:
- PATH_BASE_ADDR, 32'h0000_0100, byte address of path node 0; node i is at PATH_BASE_ADDR + 4*i.
- LEN_ADDR, 32'h0000_00FC, byte address of the path-length word.
- DEPTH, 32, buffer capacity in nodes; must be a power of two and at most 32.
- NODE_W, 5, node ID width.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- CPU_MemWrite  in  1  CPU store strobe, valid for one cycle per store.
- CPU_DataAdr  in  32  CPU store byte address.
- CPU_WriteData  in  32  CPU store data.
- CPU_stop  in  1  CPU program-finished level.
- path_clear  in  1  one-cycle pulse; discard the current path and arm capture.
- node_changed  in  1  one-cycle pulse from the follower: the current node has been reached.
- next_node  out  NODE_W  node to travel to now.
- path_valid  out  1  next_node is meaningful.
- path_len  out  6  captured length, in nodes.
- path_index  out  5  index of next_node.
- path_done  out  1  final node reached; sticky until path_clear.
- addr_err  out  1  sticky: a store landed inside the window at or above DEPTH, or length exceeded DEPTH.

Behaviour:
- Reset values: state IDLE; all outputs 0; buffer contents don't-care; stop_d (registered CPU_stop) = 0.
- States are IDLE, CAPTURE, SERVE and DONE.
- IDLE: outputs held at 0. path_clear moves to CAPTURE.
- CAPTURE: snoops only on cycles where CPU_MemWrite=1.
  - Store to LEN_ADDR: len_r <= CPU_WriteData[5:0]. If CPU_WriteData > DEPTH, set addr_err and clamp len_r to DEPTH.
  - Store in [PATH_BASE_ADDR, PATH_BASE_ADDR + 4*DEPTH): buf[(addr - PATH_BASE_ADDR) >> 2] <= CPU_WriteData[NODE_W-1:0]. The upper data bits are ignored.
  - Store to a word-aligned address at or above PATH_BASE_ADDR + 4*DEPTH and below PATH_BASE_ADDR + 128: set addr_err, no write.
  - All other addresses are ignored silently. Byte offsets addr[1:0] are ignored, so the word is selected.
  - A repeated store to the same slot overwrites it; the last write wins.
  - A rising edge of CPU_stop (CPU_stop & ~stop_d) ends capture:
    - len_r = 0: go to DONE with path_done=1 and path_valid=0.
    - Otherwise: go to SERVE with path_index=0.
- SERVE:
  - path_valid=1; next_node=buf[path_index]; path_len=len_r.
  - Outputs are registered, so next_node is valid in the first cycle of SERVE, one cycle after the CPU_stop edge.
  - On node_changed:
    - path_index < len_r-1: path_index+1; next_node updates on the following cycle.
    - path_index == len_r-1: go to DONE.
- DONE: path_valid=0, path_done=1, next_node holds the last node served. Further node_changed pulses are ignored.
- CPU_MemWrite is ignored outside CAPTURE.
- path_clear has the highest priority in every state.
  - It clears path_index, len_r, path_done, path_valid and addr_err, then enters CAPTURE on the next cycle.
  - It is honoured even if a store or node_changed arrives in the same cycle; that store is dropped.
- node_changed in the same cycle as the CPU_stop edge: the CPU_stop edge is taken and node_changed is dropped.
- A CPU_stop that is already high on entry to CAPTURE is not an edge; capture waits for a fresh rising edge.
- Asynchronous reset at any point, including mid-capture or mid-serve, returns to IDLE with all outputs 0.

Optional Feature:
- Macro: PATH_REVERSE_EN.
- When defined, the buffer is served from index len_r-1 down to 0, because the Dijkstra predecessor walk stores the path end-first.
  - path_index starts at len_r-1 and decrements on each node_changed.
  - DONE is entered on the node_changed received while path_index == 0.
- When not defined, serving is forward, 0 to len_r-1, as specified above.

Test Plan:
- Forward path: path_clear; stores LEN=3 and nodes 4, 9, 17 at base, base+4, base+8; CPU_stop rises.
  - Next cycle: path_valid=1, next_node=4, path_len=3.
  - Three node_changed pulses give next_node 9, then 17, then path_done=1, path_valid=0.
- Zero length: LEN=0 stored, then CPU_stop edge -> path_done=1, path_valid=0, next_node=0.
- Overflow: LEN=40 stored and a store to base+4*32 -> addr_err=1, path_len=32, slot 0 unchanged.
- Priority: node_changed and path_clear in the same SERVE cycle -> CAPTURE, path_index=0, path_done=0.
  - A store in that same cycle is dropped.
- Reset mid-serve: at path_index=2, assert reset -> all outputs 0 immediately (asynchronous).
  - After release, the block stays in IDLE and ignores stores until path_clear.
- PATH_REVERSE_EN: same stimulus as the forward-path test -> next_node sequence 17, 9, 4, then path_done=1.
